// File: rtl/stack_controller.sv
// Push-down stack sequencer: tracks the stack pointer and drives one-hot row
// selects and write pulses into an external array of `word` rows.
module stack_controller #(
   parameter int BUSWIDTH = 8,
   parameter int DEPTH    = 8,
   parameter int PTRWIDTH = 3
) (
   input  logic                Clk_i,
   input  logic                nRst_i,
   input  logic                Push_i,
   input  logic                Pop_i,
   input  logic [BUSWIDTH-1:0] Data_i,
   output logic [BUSWIDTH-1:0] Data_o,
   output logic                Valid_o,
   output logic                Busy_o,
   output logic                Full_o,
   output logic                Empty_o,
   output logic [PTRWIDTH:0]   Count_o,
   output logic                Err_o,
   output logic [DEPTH-1:0]    RowSel_o,
   output logic                WEn_o,
   output logic [BUSWIDTH-1:0] RamData_o,
   input  logic [BUSWIDTH-1:0] RamData_i
);

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

   state_e              state_q;
   logic [PTRWIDTH:0]   sp_q;
   logic [BUSWIDTH-1:0] ram_data_q;
   logic [BUSWIDTH-1:0] data_q;
   logic                valid_q;
   logic                err_q;
   logic                wen_q;
   logic [DEPTH-1:0]    row_sel_q;

   logic                full;
   logic                empty;
   logic                push_ok;
   logic                pop_ok;
   logic                reject;
   logic [PTRWIDTH:0]   sp_inc_d;
   logic [PTRWIDTH:0]   sp_dec_d;
   logic [DEPTH-1:0]    wr_sel_d;
   logic [DEPTH-1:0]    rd_sel_d;

   assign full     = (sp_q == (PTRWIDTH+1)'(DEPTH));
   assign empty    = (sp_q == '0);
   assign push_ok  = Push_i & ~Pop_i & ~full;
   assign pop_ok   = Pop_i & ~Push_i & ~empty;
   assign reject   = (Push_i | Pop_i) & ~push_ok & ~pop_ok;

   assign sp_inc_d = sp_q + (PTRWIDTH+1)'(1);
   assign sp_dec_d = sp_q - (PTRWIDTH+1)'(1);
   // Only the low pointer bits address a row; the MSB is set only when full.
   assign wr_sel_d = {{(DEPTH-1){1'b0}}, 1'b1} << sp_q[PTRWIDTH-1:0];
   assign rd_sel_d = {{(DEPTH-1){1'b0}}, 1'b1} << sp_dec_d[PTRWIDTH-1:0];

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would make ordering inside the block matter.
   always_ff @(posedge Clk_i or negedge nRst_i) begin
      if (!nRst_i) begin
         state_q    <= IDLE;
         sp_q       <= '0;
         ram_data_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         wen_q      <= 1'b0;
         row_sel_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (push_ok) begin
                  ram_data_q <= Data_i;
                  row_sel_q  <= wr_sel_d;
                  wen_q      <= 1'b1;
                  state_q    <= WRITE;
               end else if (pop_ok) begin
                  row_sel_q  <= rd_sel_d;
                  state_q    <= READ;
               end else if (reject) begin
                  err_q      <= 1'b1;
               end
            end
            WRITE: begin
               sp_q      <= sp_inc_d;
               wen_q     <= 1'b0;
               row_sel_q <= '0;
               state_q   <= IDLE;
            end
            READ: begin
               data_q    <= RamData_i;
               valid_q   <= 1'b1;
               sp_q      <= sp_dec_d;
               row_sel_q <= '0;
               state_q   <= IDLE;
            end
            default: begin
               wen_q     <= 1'b0;
               row_sel_q <= '0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign Data_o    = data_q;
   assign Valid_o   = valid_q;
   assign Busy_o    = (state_q != IDLE);
   assign Full_o    = full;
   assign Empty_o   = empty;
   assign Count_o   = sp_q;
   assign Err_o     = err_q;
   assign RowSel_o  = row_sel_q;
   assign WEn_o     = wen_q;
   assign RamData_o = ram_data_q;

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller with a behavioural word array attached.
module tb_stack_controller;

   localparam int BW    = 8;
   localparam int DEPTH = 8;
   localparam int PW    = 3;
   localparam int NVEC  = 23;

   logic          Clk_i = 1'b0;
   logic          nRst_i;
   logic          Push_i, Pop_i;
   logic [BW-1:0] Data_i;
   logic [BW-1:0] Data_o;
   logic          Valid_o, Busy_o, Full_o, Empty_o, Err_o, WEn_o;
   logic [PW:0]   Count_o;
   logic [DEPTH-1:0] RowSel_o;
   logic [BW-1:0] RamData_o;
   logic [BW-1:0] RamData_i;

   logic [BW-1:0] mem [DEPTH];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic          push;
      logic          pop;
      logic [BW-1:0] din;
      int            count;
      logic          wen;
      logic [7:0]    rowsel;
      logic          busy;
      logic          valid;
      logic          err;
      logic [BW-1:0] data;
   } vec_t;

   vec_t vec [NVEC];

   stack_controller #(.BUSWIDTH(BW), .DEPTH(DEPTH), .PTRWIDTH(PW)) dut (
      .Clk_i(Clk_i), .nRst_i(nRst_i), .Push_i(Push_i), .Pop_i(Pop_i),
      .Data_i(Data_i), .Data_o(Data_o), .Valid_o(Valid_o), .Busy_o(Busy_o),
      .Full_o(Full_o), .Empty_o(Empty_o), .Count_o(Count_o), .Err_o(Err_o),
      .RowSel_o(RowSel_o), .WEn_o(WEn_o), .RamData_o(RamData_o),
      .RamData_i(RamData_i)
   );

   always #5 Clk_i = ~Clk_i;

   always @(posedge Clk_i) begin
      if (WEn_o)
         for (int i = 0; i < DEPTH; i++)
            if (RowSel_o[i]) mem[i] <= RamData_o;
   end

   always_comb begin
      RamData_i = '0;
      for (int j = 0; j < DEPTH; j++)
         if (RowSel_o[j]) RamData_i = mem[j];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk_i);
      #1;
   endtask

   initial begin
      // {push, pop, din, count, wen, rowsel, busy, valid, err, data}
      vec[0]  = '{1, 0, 8'h11, 0, 1, 8'h01, 1, 0, 0, 8'h00};
      vec[1]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h00};
      vec[2]  = '{1, 0, 8'h22, 1, 1, 8'h02, 1, 0, 0, 8'h00};
      vec[3]  = '{0, 0, 8'h00, 2, 0, 8'h00, 0, 0, 0, 8'h00};
      vec[4]  = '{1, 0, 8'h33, 2, 1, 8'h04, 1, 0, 0, 8'h00};
      vec[5]  = '{0, 0, 8'h00, 3, 0, 8'h00, 0, 0, 0, 8'h00};
      vec[6]  = '{0, 1, 8'h00, 3, 0, 8'h04, 1, 0, 0, 8'h00};
      vec[7]  = '{0, 0, 8'h00, 2, 0, 8'h00, 0, 1, 0, 8'h33};
      vec[8]  = '{0, 1, 8'h00, 2, 0, 8'h02, 1, 0, 0, 8'h33};
      vec[9]  = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 8'h22};
      vec[10] = '{0, 1, 8'h00, 1, 0, 8'h01, 1, 0, 0, 8'h22};
      vec[11] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h11};
      vec[12] = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h11};
      vec[13] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h11};
      vec[14] = '{1, 1, 8'h55, 0, 0, 8'h00, 0, 0, 1, 8'h11};
      vec[15] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h11};
      vec[16] = '{1, 0, 8'h44, 0, 1, 8'h01, 1, 0, 0, 8'h11};
      vec[17] = '{0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 8'h11};
      vec[18] = '{1, 1, 8'h66, 1, 0, 8'h00, 0, 0, 1, 8'h11};
      vec[19] = '{0, 1, 8'h00, 1, 0, 8'h01, 1, 0, 0, 8'h11};
      vec[20] = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 1, 0, 8'h44};
      vec[21] = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h44};
      vec[22] = '{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h44};

      nRst_i = 1'b0;
      Push_i = 1'b0;
      Pop_i  = 1'b0;
      Data_i = '0;
      repeat (2) @(posedge Clk_i);
      #1;
      check("rst count", Count_o, 0);
      check("rst empty", Empty_o, 1);
      check("rst full", Full_o, 0);
      check("rst rowsel", RowSel_o, 0);
      check("rst wen", WEn_o, 0);
      check("rst valid", Valid_o, 0);
      check("rst err", Err_o, 0);
      check("rst data", Data_o, 0);
      check("rst ramdata", RamData_o, 0);
      nRst_i = 1'b1;
      step();
      check("post-rst busy", Busy_o, 0);
      check("post-rst count", Count_o, 0);

      for (int i = 0; i < NVEC; i++) begin
         Push_i = vec[i].push;
         Pop_i  = vec[i].pop;
         Data_i = vec[i].din;
         step();
         check($sformatf("vec%0d count", i), Count_o, vec[i].count);
         check($sformatf("vec%0d empty", i), Empty_o, vec[i].count == 0);
         check($sformatf("vec%0d full", i), Full_o, vec[i].count == DEPTH);
         check($sformatf("vec%0d wen", i), WEn_o, vec[i].wen);
         check($sformatf("vec%0d rowsel", i), RowSel_o, vec[i].rowsel);
         check($sformatf("vec%0d busy", i), Busy_o, vec[i].busy);
         check($sformatf("vec%0d valid", i), Valid_o, vec[i].valid);
         check($sformatf("vec%0d err", i), Err_o, vec[i].err);
         check($sformatf("vec%0d data", i), Data_o, vec[i].data);
      end
      Pop_i = 1'b0;

      // Push held high from empty: one accepted push every two cycles.
      Push_i = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         Data_i = 8'hA0 + 8'(k);
         step();
         check($sformatf("hold%0d wen", k), WEn_o, 1);
         check($sformatf("hold%0d rowsel", k), RowSel_o, 32'd1 << k);
         check($sformatf("hold%0d ramdata", k), RamData_o, 8'hA0 + 8'(k));
         step();
         check($sformatf("hold%0d wen off", k), WEn_o, 0);
         check($sformatf("hold%0d count", k), Count_o, k + 1);
      end
      check("full flag", Full_o, 1);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("ovf%0d err", k), Err_o, 1);
         check($sformatf("ovf%0d wen", k), WEn_o, 0);
         check($sformatf("ovf%0d count", k), Count_o, DEPTH);
      end
      Push_i = 1'b0;
      step();
      check("ovf err clear", Err_o, 0);

      // Pop held high drains the stack in LIFO order.
      Pop_i = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         step();
         check($sformatf("drain%0d rowsel", k), RowSel_o, 32'd1 << (DEPTH - 1 - k));
         check($sformatf("drain%0d valid low", k), Valid_o, 0);
         step();
         check($sformatf("drain%0d valid", k), Valid_o, 1);
         check($sformatf("drain%0d data", k), Data_o, 8'hA7 - 8'(k));
      end
      check("drain empty", Empty_o, 1);
      step();
      check("underflow err", Err_o, 1);
      check("underflow count", Count_o, 0);
      Pop_i = 1'b0;
      step();

      // Reset asserted in the middle of a WRITE cycle.
      Push_i = 1'b1;
      Data_i = 8'h77;
      step();
      check("mid wen", WEn_o, 1);
      Push_i = 1'b0;
      #2;
      nRst_i = 1'b0;
      #1;
      check("async wen", WEn_o, 0);
      check("async rowsel", RowSel_o, 0);
      check("async busy", Busy_o, 0);
      #2;
      nRst_i = 1'b1;
      step();
      check("rel count", Count_o, 0);
      check("rel empty", Empty_o, 1);
      Push_i = 1'b1;
      Data_i = 8'h99;
      step();
      Push_i = 1'b0;
      check("rel rowsel", RowSel_o, 8'h01);
      check("rel wen", WEn_o, 1);
      step();
      check("rel count1", Count_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
